// File: rtl/conv_output_packer.sv
// Word FIFO for the packer: registered storage, head word visible the cycle after its push.
// Latency: 1 cycle push-to-valid. Backpressure: o_wr_rdy drops only when full with no pop.
// A rejected write is the caller's to account for; the FIFO itself never stalls.
module conv_output_packer_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_wr_vld,
    input  logic [W-1:0] i_wr_dat,
    output logic         o_wr_rdy,
    output logic         o_rd_vld,
    output logic [W-1:0] o_rd_dat,
    input  logic         i_rd_rdy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;
    localparam logic [AW:0] PTR_WRAP = {1'b1, {AW{1'b0}}};

    logic [AW:0]  r_wr_ptr, r_rd_ptr;
    logic [W-1:0] r_mem [DEPTH];
    logic         w_empty, w_full, w_pop, w_push;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = ((r_wr_ptr ^ r_rd_ptr) == PTR_WRAP);
    assign w_pop    = i_rd_rdy & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
    assign o_wr_rdy = ~w_full | i_rd_rdy;
    assign w_push   = i_wr_vld & o_wr_rdy;
    assign o_rd_vld = ~w_empty;
    assign o_rd_dat = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_dat;
    end
endmodule

// Packs the convolution filter's 8-bit pixel stream into 32-bit words tagged sof/last.
// Latency: word visible on io_out_* one cycle after the pixel that completes it.
// Backpressure: input cannot stall; words arriving at a full FIFO are dropped and io_overflow sticks.
module conv_output_packer #(
    parameter int FIFO_DEPTH      = 8,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [9:0]                 io_image_width,
    input  logic [9:0]                 io_image_height,
    input  logic                       io_frame_sync_in,
    input  logic [7:0]                 io_data_in,
    output logic                       io_out_valid,
    input  logic                       io_out_ready,
    output logic [31:0]                io_out_data,
    output logic                       io_out_sof,
    output logic                       io_out_last,
    output logic                       io_overflow,
    output logic [FRAME_CNT_WIDTH-1:0] io_frame_count
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    typedef struct packed {
        logic        last;
        logic        sof;
        logic [31:0] data;
    } word_t;

    localparam logic [FRAME_CNT_WIDTH-1:0] FC_ONE = 1;

    state_t                     r_state;
    logic [19:0]                r_last_idx, r_count;
    logic [23:0]                r_acc;
    logic                       r_sof_pend, r_overflow;
    logic [FRAME_CNT_WIDTH-1:0] r_frame_count;

    logic [19:0] w_new_last_idx;
    logic [1:0]  w_lane;
    logic [31:0] w_pix_word;
    logic        w_final, w_push, w_frame_done, w_wr_rdy, w_rd_vld;
    word_t       w_word, w_head;

    // (w+1)*(h+1)-1 expanded so it fits 20 bits even for a 1024x1024 frame.
    assign w_new_last_idx = {10'd0, io_image_width} * {10'd0, io_image_height}
                          + {10'd0, io_image_width} + {10'd0, io_image_height};
    assign w_lane     = r_count[1:0];
    assign w_pix_word = {24'd0, io_data_in} << {w_lane, 3'b000};
    assign w_final    = (r_count == r_last_idx);

    always_comb begin
        w_push       = 1'b0;
        w_frame_done = 1'b0;
        w_word       = '0;
        if (io_frame_sync_in) begin
            // A 1-pixel frame completes on its sync; otherwise flush any partial word of the old frame.
            if (w_new_last_idx == 20'd0) begin
                w_push       = 1'b1;
                w_frame_done = 1'b1;
                w_word.data  = {24'd0, io_data_in};
                w_word.sof   = 1'b1;
                w_word.last  = 1'b1;
            end else if (r_state == ACTIVE && w_lane != 2'd0) begin
                w_push      = 1'b1;
                w_word.data = {8'd0, r_acc};
                w_word.sof  = r_sof_pend;
                w_word.last = 1'b1;
            end
        end else if (r_state == ACTIVE) begin
            w_push       = (w_lane == 2'd3) | w_final;
            w_frame_done = w_final;
            w_word.data  = {8'd0, r_acc} | w_pix_word;
            w_word.sof   = r_sof_pend;
            w_word.last  = w_final;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_last_idx    <= '0;
            r_count       <= '0;
            r_acc         <= '0;
            r_sof_pend    <= 1'b0;
            r_overflow    <= 1'b0;
            r_frame_count <= '0;
        end else begin
            if (io_frame_sync_in) begin
                r_last_idx <= w_new_last_idx;
                r_count    <= 20'd1;
                r_acc      <= {16'd0, io_data_in};
                r_sof_pend <= 1'b1;
                r_state    <= (w_new_last_idx == 20'd0) ? IDLE : ACTIVE;
            end else if (r_state == ACTIVE) begin
                r_count <= r_count + 20'd1;
                if (w_push) begin
                    r_acc      <= '0;
                    r_sof_pend <= 1'b0;
                end else begin
                    r_acc <= w_word.data[23:0];
                end
                if (w_final) r_state <= IDLE;
            end
            if (w_push && !w_wr_rdy) r_overflow <= 1'b1;
            if (w_frame_done) r_frame_count <= r_frame_count + FC_ONE;
        end
    end

    conv_output_packer_fifo #(
        .W     ($bits(word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .i_wr_vld (w_push),
        .i_wr_dat (w_word),
        .o_wr_rdy (w_wr_rdy),
        .o_rd_vld (w_rd_vld),
        .o_rd_dat (w_head),
        .i_rd_rdy (io_out_ready)
    );

    assign io_out_valid   = w_rd_vld;
    assign io_out_data    = w_head.data;
    assign io_out_sof     = w_head.sof;
    assign io_out_last    = w_head.last;
    assign io_overflow    = r_overflow;
    assign io_frame_count = r_frame_count;
endmodule
